demux_reg: RTL and testbench

DEMUX_REG -- requirements
Module: demux_reg

---
 rtl/demux_reg.sv | 180 ++++++++++++++++++
 tb/tb_demux_reg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_reg
// Description : 1-to-4 registered demultiplexer with valid/ready handshakes.
//               A word offered on d is routed by {s1,s0} into one of four
//               one-entry holding registers. Each channel drains on its own
//               handshake (vk/rk) independently of the others.
//
// Ports       : clk        - single clock, rising edge
//               rst        - asynchronous, active-high reset
//               s1, s0     - channel select, {s1,s0} = channel index 0..3
//               d          - input data word (WIDTH bits)
//               in_valid   - d and select are valid this cycle
//               in_ready   - block accepts the word this cycle (combinational)
//               y0..y3     - registered channel data
//               v0..v3     - channel holds a valid word
//               r0..r3     - downstream ready per channel
//               cnt0..cnt3 - saturating per-channel input transfer counters
//                            (present only when DEMUX_CNT_EN is defined)
//
// Options     : `define DEMUX_CNT_EN to add the cnt0..cnt3 counter outputs.
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    input  logic             r3
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_NUM_CH   = 4;
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    // ------------------------------------------------------------------------
    // Per-channel state and data
    // ------------------------------------------------------------------------
    logic [0:0]       r_state [c_NUM_CH];
    logic [WIDTH-1:0] r_data  [c_NUM_CH];

    logic [1:0]          w_sel;
    logic [c_NUM_CH-1:0] w_out_ready;
    logic [c_NUM_CH-1:0] w_full;
    logic                w_sel_full;
    logic                w_sel_out_ready;
    logic                w_in_xfer;
    logic [c_NUM_CH-1:0] w_load;
    logic [c_NUM_CH-1:0] w_drain;

    assign w_sel       = {s1, s0};
    assign w_out_ready = {r3, r2, r1, r0};

    // ------------------------------------------------------------------------
    // Input acceptance
    // A FULL channel can still take a new word when its downstream is ready
    // in the same cycle: the old word leaves as the new one arrives, so the
    // holding register never shows a bubble. in_valid deliberately plays no
    // part here so upstream may wait for in_ready before asserting valid.
    // ------------------------------------------------------------------------
    assign w_sel_full      = w_full[w_sel];
    assign w_sel_out_ready = w_out_ready[w_sel];
    assign in_ready        = !w_sel_full || w_sel_out_ready;
    assign w_in_xfer       = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Channel holding registers
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < c_NUM_CH; k++) begin : g_chan
            assign w_full[k]  = (r_state[k] == c_ST_FULL);
            assign w_load[k]  = w_in_xfer && (w_sel == 2'(k));
            assign w_drain[k] = w_full[k] && w_out_ready[k];

            // Two-state occupancy machine. A load always leaves the channel
            // FULL, whether or not the previous word drained this cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state[k] <= c_ST_EMPTY;
                end else begin
                    case (r_state[k])
                        c_ST_EMPTY: begin
                            if (w_load[k]) begin
                                r_state[k] <= c_ST_FULL;
                            end
                        end
                        c_ST_FULL: begin
                            if (w_load[k]) begin
                                r_state[k] <= c_ST_FULL;
                            end else if (w_drain[k]) begin
                                r_state[k] <= c_ST_EMPTY;
                            end
                        end
                        default: begin
                            r_state[k] <= c_ST_EMPTY;
                        end
                    endcase
                end
            end

            // Data only moves on a load, so a stalled word stays put and the
            // last word stays visible after the channel drains.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data[k] <= '0;
                end else if (w_load[k]) begin
                    r_data[k] <= d;
                end
            end
        end : g_chan
    endgenerate

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign y0 = r_data[0];
    assign y1 = r_data[1];
    assign y2 = r_data[2];
    assign y3 = r_data[3];

    assign v0 = w_full[0];
    assign v1 = w_full[1];
    assign v2 = w_full[2];
    assign v3 = w_full[3];

`ifdef DEMUX_CNT_EN
    // ------------------------------------------------------------------------
    // Per-channel input transfer counters, saturating at all-ones
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    logic [7:0] r_cnt [c_NUM_CH];

    generate
        for (genvar k = 0; k < c_NUM_CH; k++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[k] <= '0;
                end else if (w_load[k] && (r_cnt[k] != c_CNT_MAX)) begin
                    r_cnt[k] <= r_cnt[k] + 8'd1;
                end
            end
        end : g_cnt
    endgenerate

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];
`endif

endmodule : demux_reg
`default_nettype wire

// File: tb/tb_demux_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_reg
// Description : Self-checking bench for demux_reg. A driver issues directed
//               and randomized stimulus and pushes each accepted word into a
//               per-channel expectation queue; a separate monitor pops and
//               compares whenever a channel presents an output transfer.
//               Counter checks are compiled in with DEMUX_CNT_EN.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_reg;

    localparam int c_W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s1 = 1'b0;
    logic           s0 = 1'b0;
    logic [c_W-1:0] d = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [c_W-1:0] y0, y1, y2, y3;
    logic           v0, v1, v2, v3;
    logic           r0 = 1'b0;
    logic           r1 = 1'b0;
    logic           r2 = 1'b0;
    logic           r3 = 1'b0;
`ifdef DEMUX_CNT_EN
    logic [7:0]     cnt0, cnt1, cnt2, cnt3;
`endif

    demux_reg #(.WIDTH(c_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s1       (s1),
        .s0       (s0),
        .d        (d),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .v0       (v0),
        .v1       (v1),
        .v2       (v2),
        .v3       (v3),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
`endif
    );

    always #5 clk = ~clk;

    // Convenience views of the four channels
    logic [c_W-1:0] w_y [4];
    logic [3:0]     w_v;
    logic [3:0]     w_r;
    assign w_y[0] = y0;
    assign w_y[1] = y1;
    assign w_y[2] = y2;
    assign w_y[3] = y3;
    assign w_v    = {v3, v2, v1, v0};
    assign w_r    = {r3, r2, r1, r0};

    // ------------------------------------------------------------------------
    // Reference model: per-channel queue of words the channel must emit,
    // occupancy flags, last emitted word and transfer counts.
    // ------------------------------------------------------------------------
    logic [c_W-1:0] q [4][$];
    logic [3:0]     m_full;
    logic [c_W-1:0] m_last [4];
    int             m_cnt [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            m_last[k] = '0;
            m_cnt[k]  = 0;
        end
        m_full = '0;
    endtask

    // One clock of stimulus: drive on the falling edge, settle, check the
    // combinational handshake and occupancy, then advance the model to the
    // state expected after the next rising edge.
    task automatic cycle(input logic vld, input logic [1:0] sel,
                         input logic [c_W-1:0] data, input logic [3:0] rdy);
        logic exp_ready;
        @(negedge clk);
        in_valid = vld;
        {s1, s0} = sel;
        d        = data;
        {r3, r2, r1, r0} = rdy;
        #1;
        exp_ready = !m_full[sel] || rdy[sel];
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("valid_flags", 32'(w_v), 32'(m_full));
`ifdef DEMUX_CNT_EN
        chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
        chk("cnt2", 32'(cnt2), 32'(m_cnt[2]));
        chk("cnt3", 32'(cnt3), 32'(m_cnt[3]));
`endif
        for (int k = 0; k < 4; k++) begin
            if (m_full[k] && rdy[k]) m_full[k] = 1'b0;
        end
        if (vld && exp_ready) begin
            q[sel].push_back(data);
            m_full[sel] = 1'b1;
            if (m_cnt[sel] < 255) m_cnt[sel]++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: a FULL channel must show the oldest pending word; it is popped
    // when the channel's output handshake completes. An EMPTY channel must
    // still show the last word it emitted.
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int k = 0; k < 4; k++) begin
                    if (w_v[k]) begin
                        if (q[k].size() == 0) begin
                            chk($sformatf("unexpected_valid_ch%0d", k), 32'(w_v[k]), 32'd0);
                        end else begin
                            chk($sformatf("y%0d_data", k), 32'(w_y[k]), 32'(q[k][0]));
                            if (w_r[k]) begin
                                m_last[k] = q[k].pop_front();
                            end
                        end
                    end else begin
                        chk($sformatf("y%0d_retained", k), 32'(w_y[k]), 32'(m_last[k]));
                    end
                end
            end
        end
    end

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_valid", 32'(w_v), 32'd0);
        chk("rst_y0", 32'(y0), 32'd0);
        chk("rst_y1", 32'(y1), 32'd0);
        chk("rst_y2", 32'(y2), 32'd0);
        chk("rst_y3", 32'(y3), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        chk("init_rst_valid", 32'(w_v), 32'd0);
        chk("init_rst_y0", 32'(y0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic routing to channel 2, channel stalled
        cycle(1'b1, 2'b10, 8'hA5, 4'b0000);
        cycle(1'b0, 2'b00, 8'h00, 4'b0000);
        chk("route_v2", 32'(v2), 32'd1);
        chk("route_y2", 32'(y2), 32'hA5);

        // Backpressure on channel 1, then pass-through with no bubble
        cycle(1'b1, 2'b01, 8'h11, 4'b0000);
        cycle(1'b1, 2'b01, 8'h3C, 4'b0000);
        cycle(1'b1, 2'b01, 8'h3C, 4'b0010);
        cycle(1'b0, 2'b00, 8'h00, 4'b0000);
        chk("pass_y1", 32'(y1), 32'h3C);
        chk("pass_v1", 32'(v1), 32'd1);

        // Select switching under stall: move from stalled ch1 to empty ch3
        cycle(1'b1, 2'b01, 8'h77, 4'b0000);
        cycle(1'b1, 2'b11, 8'h77, 4'b0000);
        cycle(1'b0, 2'b00, 8'h00, 4'b0000);
        chk("switch_y3", 32'(y3), 32'h77);
        chk("switch_y1", 32'(y1), 32'h3C);

        // All four channels drain together
        cycle(1'b0, 2'b00, 8'h00, 4'b1111);
        cycle(1'b0, 2'b00, 8'h00, 4'b0000);

        // Fill all channels then reset mid-cycle
        for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 8'(8'hC0 + k), 4'b0000);
        cycle(1'b0, 2'b00, 8'h00, 4'b0000);
        async_reset();
        // First edge after reset must accept
        cycle(1'b1, 2'b00, 8'h5A, 4'b0000);
        cycle(1'b0, 2'b00, 8'h00, 4'b1111);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom));
        end
        repeat (3) cycle(1'b0, 2'b00, 8'h00, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drained_q%0d", k), 32'(q[k].size()), 32'd0);
        end

`ifdef DEMUX_CNT_EN
        // Counter saturation on channel 0
        async_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 2'b00, 8'($urandom), 4'b0001);
        cycle(1'b0, 2'b00, 8'h00, 4'b1111);
        chk("sat_cnt0", 32'(cnt0), 32'd255);
        chk("sat_cnt1", 32'(cnt1), 32'd0);
        chk("sat_cnt2", 32'(cnt2), 32'd0);
        chk("sat_cnt3", 32'(cnt3), 32'd0);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux_reg
`default_nettype wire
